// File: rtl/pulse_scheduler.sv
// ============================================================================
// Module   : pulse_scheduler
// Purpose  : Round-robin arbiter sharing one pulse output between requesters,
//            with cycle-counted pulse widths and a minimum low gap.
//            Define PULSE_SCHED_ABORT_EN to add the `abort` input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int W100_CYC = 5,
    parameter int W500_CYC = 25,
    parameter int W1US_CYC = 50,
    parameter int GAP_CYC  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [2*NUM_REQ-1:0]   req_width,
`ifdef PULSE_SCHED_ABORT_EN
    input  logic                   abort,
`endif
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic                   pulse,
    output logic                   busy
);

    localparam int CNT_MAX = (W1US_CYC > GAP_CYC) ? W1US_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t               r_state, w_state_nx;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nx;
    logic [IDX_W-1:0]     r_ptr, w_ptr_nx;
    logic [IDX_W-1:0]     r_idx, w_idx_nx;
    logic                 r_pulse, w_pulse_nx;
    logic                 r_busy, w_busy_nx;
    logic [NUM_REQ-1:0]   r_grant, w_grant_nx;
    logic [NUM_REQ-1:0]   r_done, w_done_nx;

    logic                 w_found;
    logic [IDX_W-1:0]     w_win;
    logic [IDX_W-1:0]     w_cand_idx;
    int                   w_cand;
    logic [1:0]           w_code;
    logic                 w_abort;

`ifdef PULSE_SCHED_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    function automatic logic [CNT_W-1:0] code_cycles(input logic [1:0] code);
        case (code)
            2'b01:   code_cycles = CNT_W'(W500_CYC);
            2'b10:   code_cycles = CNT_W'(W1US_CYC);
            default: code_cycles = CNT_W'(W100_CYC);   // 11 is reserved -> shortest width
        endcase
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    // Round-robin search: first asserted request strictly after the pointer, wrapping.
    always_comb begin
        w_found    = 1'b0;
        w_win      = r_ptr;
        w_cand     = 0;
        w_cand_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand     = (int'(r_ptr) + k) % NUM_REQ;
            w_cand_idx = IDX_W'(w_cand);
            if (!w_found && req[w_cand_idx]) begin
                w_found = 1'b1;
                w_win   = w_cand_idx;
            end
        end
    end

    assign w_code = req_width[{w_win, 1'b0} +: 2];

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_ptr_nx   = r_ptr;
        w_idx_nx   = r_idx;
        w_pulse_nx = 1'b0;
        w_grant_nx = '0;
        w_done_nx  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nx = S_PULSE;
                    w_cnt_nx   = code_cycles(w_code);
                    w_ptr_nx   = w_win;
                    w_idx_nx   = w_win;
                    w_pulse_nx = 1'b1;
                    w_grant_nx = onehot(w_win);
                end
            end
            S_PULSE: begin
                if (w_abort || r_cnt == CNT_W'(1)) begin
                    w_state_nx = S_GAP;
                    w_cnt_nx   = CNT_W'(GAP_CYC);
                    w_done_nx  = onehot(r_idx);
                end else begin
                    w_cnt_nx   = r_cnt - CNT_W'(1);
                    w_pulse_nx = 1'b1;
                end
            end
            S_GAP: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx   = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
        w_busy_nx = (w_state_nx != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ptr   <= IDX_W'(NUM_REQ - 1);
            r_idx   <= '0;
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
            r_grant <= '0;
            r_done  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_ptr   <= w_ptr_nx;
            r_idx   <= w_idx_nx;
            r_pulse <= w_pulse_nx;
            r_busy  <= w_busy_nx;
            r_grant <= w_grant_nx;
            r_done  <= w_done_nx;
        end
    end

    assign grant = r_grant;
    assign done  = r_done;
    assign pulse = r_pulse;
    assign busy  = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_pulse_scheduler.sv
// ============================================================================
// Module   : tb_pulse_scheduler
// Purpose  : Randomized scoreboard bench for pulse_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pulse_scheduler;

    localparam int NUM_REQ = 4;
    localparam int W100    = 5;
    localparam int W500    = 25;
    localparam int W1US    = 50;
    localparam int GAP     = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req;
    logic [2*NUM_REQ-1:0] req_width;
    logic                 abort;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   done;
    logic                 pulse;
    logic                 busy;

    pulse_scheduler #(
        .NUM_REQ (NUM_REQ),
        .W100_CYC(W100),
        .W500_CYC(W500),
        .W1US_CYC(W1US),
        .GAP_CYC (GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_width(req_width),
`ifdef PULSE_SCHED_ABORT_EN
        .abort    (abort),
`endif
        .grant    (grant),
        .done     (done),
        .pulse    (pulse),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int idx;
        int w;
        int start;
    } txn_t;

    txn_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int m_ptr;
    int idle_at;
    int last_win;
    int last_start;
    int abort_cut = 0;
    bit drop_on_grant = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    function automatic int width_of(input logic [1:0] code);
        case (code)
            2'b01:   return W500;
            2'b10:   return W1US;
            default: return W100;
        endcase
    endfunction

    task automatic model_reset();
        m_ptr   = NUM_REQ - 1;
        idle_at = cyc;
        exp_q.delete();
    endtask

    // Decide, from the inputs driven this cycle, whether a pulse is granted next cycle.
    task automatic model_step();
        txn_t t;
        int   w;
        last_win = -1;
        if (cyc >= idle_at && req != '0) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                int i;
                i = (m_ptr + k) % NUM_REQ;
                if (last_win < 0 && req[i]) last_win = i;
            end
            w = width_of(req_width[2*last_win +: 2]);
            if (abort_cut > 0 && abort_cut < w) w = abort_cut;
            t.idx   = last_win;
            t.w     = w;
            t.start = cyc + 1;
            exp_q.push_back(t);
            last_start = cyc + 1;
            m_ptr   = last_win;
            idle_at = cyc + w + GAP + 1;
        end
    endtask

    task automatic step();
        int g;
        model_step();
        g = last_win;
        @(posedge clk);
        #1;
        if (g >= 0 && drop_on_grant) req[g] = 1'b0;
    endtask

    task automatic wait_idle();
        req = '0;
        while (cyc < idle_at) step();
    endtask

    // Monitor: derives expected outputs from the transaction in flight
    txn_t               cur;
    bit                 cur_v = 1'b0;
    logic [NUM_REQ-1:0] e_grant, e_done;
    logic               e_pulse, e_busy;

    always @(negedge clk) begin
        if (rst) begin
            cur_v = 1'b0;
            check("rst_grant", 32'(grant), 32'd0);
            check("rst_done",  32'(done),  32'd0);
            check("rst_pulse", 32'(pulse), 32'd0);
            check("rst_busy",  32'(busy),  32'd0);
        end else begin
            if (exp_q.size() > 0 && exp_q[0].start == cyc) begin
                cur   = exp_q.pop_front();
                cur_v = 1'b1;
            end
            e_grant = '0;
            e_done  = '0;
            e_pulse = 1'b0;
            e_busy  = 1'b0;
            if (cur_v) begin
                if (cyc == cur.start)        e_grant[cur.idx] = 1'b1;
                if (cyc == cur.start + cur.w) e_done[cur.idx] = 1'b1;
                e_pulse = (cyc >= cur.start) && (cyc < cur.start + cur.w);
                e_busy  = (cyc >= cur.start) && (cyc < cur.start + cur.w + GAP);
            end
            check("grant", 32'(grant), 32'(e_grant));
            check("done",  32'(done),  32'(e_done));
            check("pulse", 32'(pulse), 32'(e_pulse));
            check("busy",  32'(busy),  32'(e_busy));
        end
    end

    initial begin
        int s;
        rst       = 1'b1;
        req       = '0;
        req_width = '0;
        abort     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Single request, shortest width
        req = 4'b0001;
        step();
        wait_idle();

        // Requester 2 through width codes 01, 10, 11
        for (int c = 1; c <= 3; c++) begin
            req_width[5:4] = 2'(c);
            req[2] = 1'b1;
            step();
            wait_idle();
        end

        // All requesters held high: grants rotate
        req_width     = '0;
        drop_on_grant = 1'b0;
        req           = '1;
        repeat (40) step();
        drop_on_grant = 1'b1;
        wait_idle();

        // Withdrawal during another pulse and width change mid-pulse
        req = 4'b0001;
        req_width[1:0] = 2'b01;
        step();
        req_width[1:0] = 2'b10;
        req[1] = 1'b1;
        step();
        req[1] = 1'b0;
        wait_idle();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 5) == 0) req[i] = 1'b1;
                end else if ($urandom_range(0, 19) == 0) begin
                    req[i] = 1'b0;
                end
                if ($urandom_range(0, 3) == 0) req_width[2*i +: 2] = 2'($urandom_range(0, 3));
            end
            step();
        end
        wait_idle();

        // Asynchronous reset ten cycles into a long pulse
        req_width[5:4] = 2'b10;
        req[2] = 1'b1;
        step();
        s = last_start;
        while (cyc < s + 10) step();
        #2;
        rst = 1'b1;
        #1;
        check("arst_pulse", 32'(pulse), 32'd0);
        check("arst_busy",  32'(busy),  32'd0);
        check("arst_grant", 32'(grant), 32'd0);
        check("arst_done",  32'(done),  32'd0);
        exp_q.delete();
        cur_v = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        req = 4'b0101;
        step();
        wait_idle();

`ifdef PULSE_SCHED_ABORT_EN
        // Abort in the seventh cycle of a 1 us pulse
        req_width[1:0] = 2'b10;
        req[0]    = 1'b1;
        abort_cut = 7;
        step();
        abort_cut = 0;
        s = last_start;
        while (cyc < s + 6) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        wait_idle();
`endif

        repeat (5) step();
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
